mem_load_unit: RTL

Load-side counterpart of the MEM-stage store formatter: it drives read transactions on the data SRAM-like bus and returns aligned, sign/zero-extended load data to the MEM/WB boundary. For every load in MEM it checks alignment, issues a single read request, waits for the response, and formats the returned word. While the transaction is outstanding it stalls the pipeline, and it discards responses belonging to flushed instructions.

---
 rtl/mem_load_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: issues one read on the data SRAM-like bus per load and
// returns aligned, sign/zero-extended data, stalling while the read is in flight.
module mem_load_unit #(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        MEM_ReadMem,
    input  logic [1:0]  MEM_LoadSize,
    input  logic        MEM_LoadUnsigned,
    input  logic [31:0] MEM_ALUOut,
    input  logic        MEM_Flush,
    input  logic        WB_AllowIn,
    output logic        data_sram_req,
    output logic [31:0] data_sram_addr,
    output logic [1:0]  data_sram_size,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] MEM_DMOut,
    output logic        MEM_LoadValid,
    output logic        MEM_Stall,
    output logic        MEM_RdWrongAddr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Bus handshake: a request is held (req=1, addr/size stable) until the cycle
    // addr_ok is high; exactly one data_ok follows in a later cycle.
    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] dmout_q, dmout_d;

    logic        is_half;
    logic        is_byte;
    logic        is_word;
    logic        launch;
    logic [31:0] mapped_addr;
    logic [1:0]  bus_size;
    logic [31:0] lane;
    logic [15:0] half_v;
    logic [31:0] fmt_data;

    assign is_half = (MEM_LoadSize == 2'b01);
    assign is_byte = (MEM_LoadSize == 2'b10);
    assign is_word = !is_half && !is_byte;

    assign MEM_RdWrongAddr = MEM_ReadMem &
                             ((is_word & (MEM_ALUOut[1:0] != 2'b00)) |
                              (is_half & MEM_ALUOut[0]));

    assign launch = (state_q == S_IDLE) & MEM_ReadMem & !MEM_RdWrongAddr & !MEM_Flush;

    // kseg0/kseg1 (0x8xxx_xxxx..0xBxxx_xxxx) fold onto physical by dropping addr[31:29]
    assign mapped_addr = (ADDR_MAP_EN && MEM_ALUOut[31:30] == 2'b10)
                         ? {3'b000, MEM_ALUOut[28:0]} : MEM_ALUOut;
    assign bus_size    = is_byte ? 2'b00 : (is_half ? 2'b01 : 2'b10);

    assign lane   = data_sram_rdata >> {off_q, 3'b000};
    assign half_v = off_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

    always_comb begin
        fmt_data = data_sram_rdata;
        case (size_q)
            2'b00:   fmt_data = {{24{lane[7] & !uns_q}}, lane[7:0]};
            2'b01:   fmt_data = {{16{half_v[15] & !uns_q}}, half_v};
            default: fmt_data = data_sram_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        off_d     = off_q;
        dmout_d   = dmout_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_REQ;
                    addr_d  = mapped_addr;
                    size_d  = bus_size;
                    uns_d   = MEM_LoadUnsigned;
                    off_d   = MEM_ALUOut[1:0];
                end
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    state_d   = S_WAIT;
                    discard_d = MEM_Flush;
                end else if (MEM_Flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (MEM_Flush) begin
                    discard_d = 1'b1;
                end
                if (data_sram_data_ok) begin
                    if (discard_q || MEM_Flush) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        dmout_d = fmt_data;
                    end
                end
            end
            S_DONE: begin
                if (WB_AllowIn || MEM_Flush) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            addr_q    <= 32'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            off_q     <= 2'd0;
            dmout_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            off_q     <= off_d;
            dmout_q   <= dmout_d;
        end
    end

    assign data_sram_req  = (state_q == S_REQ);
    assign data_sram_addr = addr_q;
    assign data_sram_size = size_q;
    assign MEM_DMOut      = dmout_q;
    assign MEM_LoadValid  = (state_q == S_DONE);
    assign MEM_Stall      = launch | (state_q == S_REQ) | (state_q == S_WAIT);
    assign dbg_state      = state_q;

endmodule
